// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: MSB-first word assembly with an ack handshake and overrun/frame flags.
// Optional bit-period prescaler enabled by defining SIPO_TICK_DIV_EN (tick every 2^DIV_LOG2 cycles).
module sipo_rx #(
    parameter int WIDTH    = 4,
    parameter int DIV_LOG2 = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             s,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             tick;

    assign shifted = {shreg[WIDTH-2:0], sin};

`ifdef SIPO_TICK_DIV_EN
    logic [DIV_LOG2-1:0] prescale;

    always_ff @(posedge clk) begin
        if (rst) prescale <= '0;
        else     prescale <= prescale + 1'b1;
    end

    assign tick = &prescale;
`else
    logic unused_div;
    assign unused_div = ^DIV_LOG2;
    assign tick       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A completing word below overrides this clear, so ack+completion keeps valid high.
            if (ack && dout_valid) dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    count <= '0;
                    if (s && tick) begin
                        shreg <= shifted;
                        count <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!s) begin
                        // s is watched every cycle, so an abort never waits for a tick.
                        if (count != '0) frame_err <= 1'b1;
                        shreg <= '0;
                        count <= '0;
                        state <= IDLE;
                    end else if (tick) begin
                        shreg <= shifted;
                        if (count == LAST) begin
                            dout       <= shifted;
                            dout_valid <= 1'b1;
                            if (dout_valid && !ack) overrun <= 1'b1;
                            count      <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (WIDTH=4); the divided-tick scenario runs when SIPO_TICK_DIV_EN is defined.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       s;
    logic       ack;
    logic [3:0] dout;
    logic       dout_valid;
    logic       overrun;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    sipo_rx #(.WIDTH(4), .DIV_LOG2(2)) dut (
        .clk(clk), .rst(rst), .sin(sin), .s(s), .ack(ack),
        .dout(dout), .dout_valid(dout_valid), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s   = 1'b1;
        sin = b;
        step();
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle_cycle(input logic a);
        s   = 1'b0;
        sin = 1'b0;
        ack = a;
        step();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s   = 1'b0;
        sin = 1'b0;
        ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_dout",    32'(dout),       32'h0);
        chk("rst_valid",   32'(dout_valid), 32'h0);
        chk("rst_overrun", 32'(overrun),    32'h0);
        chk("rst_ferr",    32'(frame_err),  32'h0);

`ifdef SIPO_TICK_DIV_EN
        // Prescaler restarts at 0 on reset release: ticks land on every 4th edge.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        chk("div_not_yet", 32'(dout_valid), 32'h0);
        send_bit(1'b0);
        chk("div_dout",  32'(dout),       32'b1110);
        chk("div_valid", 32'(dout_valid), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("div_midbit_noerr", 32'(frame_err), 32'h0);
        idle_cycle(1'b0);
        chk("div_ferr",       32'(frame_err),  32'h1);
        chk("div_ferr_dout",  32'(dout),       32'b1110);
        chk("div_ferr_valid", 32'(dout_valid), 32'h1);
        idle_cycle(1'b0);
        chk("div_ferr_pulse", 32'(frame_err), 32'h0);
`else
        // Basic word and latency
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("basic_latency", 32'(dout_valid), 32'h0);
        send_bit(1'b1);
        chk("basic_dout",  32'(dout),       32'b1011);
        chk("basic_valid", 32'(dout_valid), 32'h1);
        idle_cycle(1'b1);
        chk("basic_ack_valid", 32'(dout_valid), 32'h0);
        chk("basic_ack_dout",  32'(dout),       32'b1011);
        chk("basic_end_noerr", 32'(frame_err),  32'h0);

        // Back-to-back words, ack during the second word
        send_word(4'b1100);
        chk("b2b_dout1",  32'(dout),       32'b1100);
        chk("b2b_valid1", 32'(dout_valid), 32'h1);
        ack = 1'b1;
        send_bit(1'b0);
        ack = 1'b0;
        chk("b2b_acked", 32'(dout_valid), 32'h0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("b2b_dout2",   32'(dout),       32'b0110);
        chk("b2b_valid2",  32'(dout_valid), 32'h1);
        chk("b2b_overrun", 32'(overrun),    32'h0);
        idle_cycle(1'b1);

        // Overrun
        send_word(4'b1010);
        send_word(4'b0101);
        chk("ovr_dout",  32'(dout),       32'b0101);
        chk("ovr_valid", 32'(dout_valid), 32'h1);
        chk("ovr_flag",  32'(overrun),    32'h1);
        idle_cycle(1'b1);
        chk("ovr_ack_valid", 32'(dout_valid), 32'h0);
        chk("ovr_sticky",    32'(overrun),    32'h1);
        do_reset();
        chk("ovr_rst", 32'(overrun), 32'h0);

        // Frame error after 2 bits, then after WIDTH-1 bits
        send_word(4'b0110);
        idle_cycle(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        idle_cycle(1'b0);
        chk("ferr2_pulse", 32'(frame_err),  32'h1);
        chk("ferr2_dout",  32'(dout),       32'b0110);
        chk("ferr2_valid", 32'(dout_valid), 32'h1);
        idle_cycle(1'b1);
        chk("ferr2_one_cycle", 32'(frame_err), 32'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle_cycle(1'b0);
        chk("ferr3_pulse", 32'(frame_err), 32'h1);
        send_word(4'b0011);
        chk("ferr_next_dout",  32'(dout),       32'b0011);
        chk("ferr_next_valid", 32'(dout_valid), 32'h1);
        chk("ferr_next_ovr",   32'(overrun),    32'h0);

        // Reset mid-word
        send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1;
        s   = 1'b0;
        step();
        rst = 1'b0;
        chk("rstmid_dout",  32'(dout),       32'h0);
        chk("rstmid_valid", 32'(dout_valid), 32'h0);
        chk("rstmid_ferr",  32'(frame_err),  32'h0);
        idle_cycle(1'b0);
        chk("rstmid_noerr", 32'(frame_err), 32'h0);

        // Ack on the completion edge while a previous word is still valid
        send_word(4'b0110);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        ack = 1'b1;
        send_bit(1'b1);
        ack = 1'b0;
        chk("simack_dout",  32'(dout),       32'b1001);
        chk("simack_valid", 32'(dout_valid), 32'h1);
        chk("simack_ovr",   32'(overrun),    32'h0);
        idle_cycle(1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
